native_mem_initiator: RTL and testbench

Bus initiator for the native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) that the core drives toward the word memory.
- Takes single read/write commands on a valid/ready command port and runs each as one native-bus transaction.
- Returns read data and status on a valid/ready response port.
- Used for memory preload and checkpoint readback while the core is held in reset, and as a standalone bus stimulus source.

---
 rtl/native_mem_pkg.sv | 24 ++
 rtl/native_mem_initiator_if.sv | 46 ++++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/native_mem_initiator.sv | 102 ++++++++++
 tb/tb_native_mem_initiator.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/native_mem_pkg.sv
// Shared types and constants for the native memory bus initiator.
package native_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int STRB_W     = 4;
  localparam int WORD_LSB   = $clog2(WORD_BYTES);

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;

  // A command is rejected without a bus cycle if misaligned or a write with no byte enabled.
  function automatic logic cmd_err(input logic [WORD_LSB-1:0] addr_lo,
                                   input logic                we,
                                   input logic [STRB_W-1:0]   strb);
    return (addr_lo != '0) || (we && (strb == '0));
  endfunction

endpackage

// File: rtl/native_mem_initiator_if.sv
// Command, response and native memory bus signals of the initiator; master is the initiator side.
interface native_mem_initiator_if
  import native_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_valid;
  logic              mem_instr;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts REQ cycles without mem_ready; tc flags the last allowed wait cycle.
// Latency: tc is combinational from the count; clear has priority over enable.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/native_mem_initiator.sv
// Runs one native-bus transaction per accepted command; min 2 cycles accept-to-rsp_valid, 3 per command.
// Single outstanding command; NATIVE_MEM_INITIATOR_TIMEOUT_EN bounds the wait for mem_ready.
module native_mem_initiator
  import native_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  native_mem_initiator_if.master bus,
  output logic                   busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  logic   accept;
  logic   bad_cmd;
  logic   is_read;
  logic   wait_tc;

  assign accept        = bus.cmd_valid && (state == IDLE);
  assign bad_cmd       = cmd_err(bus.cmd_addr[WORD_LSB-1:0], bus.cmd_we, bus.cmd_wstrb);
  assign is_read       = (bus.mem_wstrb == '0);
  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign bus.mem_instr = 1'b0;

`ifdef NATIVE_MEM_INITIATOR_TIMEOUT_EN
  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable ((state == REQ) && !bus.mem_ready),
    .tc     (wait_tc)
  );
`else
  assign wait_tc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= ERR_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (bad_cmd) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= ERR_SET;
              bus.rsp_rdata <= {DATA_W{1'b0}};
            end else begin
              state         <= REQ;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= {bus.cmd_addr[ADDR_W-1:WORD_LSB], WORD_LSB'(0)};
              bus.mem_wstrb <= bus.cmd_we ? bus.cmd_wstrb : '0;
              bus.mem_wdata <= bus.cmd_we ? bus.cmd_wdata : {DATA_W{1'b0}};
            end
          end
        end
        REQ: begin
          // mem_ready wins over the terminal count, so a late ready still succeeds.
          if (bus.mem_ready) begin
            state         <= RESP;
            bus.mem_valid <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= ERR_NONE;
            bus.rsp_rdata <= is_read ? bus.mem_rdata : {DATA_W{1'b0}};
          end else if (wait_tc) begin
            state         <= RESP;
            bus.mem_valid <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= ERR_SET;
            bus.rsp_rdata <= {DATA_W{1'b0}};
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_native_mem_initiator.sv
// Self-checking bench: directed vector table, hand sequences, then random commands vs a byte-level memory model.
module tb_native_mem_initiator;

  logic clk;
  logic reset;
  logic busy;

  native_mem_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  native_mem_initiator #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // responder controls and bus-side memory
  int          wait_target = 0;
  bit          ready_en    = 1'b1;
  bit          stray_en    = 1'b0;
  int          mv_count    = 0;
  int          wcnt        = 0;
  logic [31:0] rmem [16];

  // expected request fields of the command in flight
  logic [31:0] exp_maddr;
  logic [31:0] exp_mwdata;
  logic [3:0]  exp_mwstrb;

  // reference model: plain byte-addressed memory
  logic [7:0]  ref_bytes [64];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wt;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_mv;
    int          exp_lat;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid) begin
        mv_count++;
        check("mem_addr", bus.mem_addr, exp_maddr);
        check("mem_wdata", bus.mem_wdata, exp_mwdata);
        check("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_mwstrb));
        check("mem_instr", 32'(bus.mem_instr), 32'h0);
        if (ready_en && wcnt >= wait_target) begin
          if (bus.mem_wstrb == 4'h0) begin
            bus.mem_rdata = rmem[bus.mem_addr[5:2]];
          end else begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) rmem[bus.mem_addr[5:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            bus.mem_rdata = $urandom;
          end
          bus.mem_ready = 1'b1;
          wcnt = 0;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        bus.mem_rdata = $urandom;
        bus.mem_ready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = strb;
    bus.cmd_valid = 1'b1;
    exp_maddr  = addr & 32'hFFFF_FFFC;
    exp_mwdata = we ? wdata : 32'h0;
    exp_mwstrb = we ? strb : 4'h0;
  endtask

  task automatic accept(input string nm);
    int g = 0;
    while (!bus.cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({nm, "_accept"}, 32'(bus.cmd_ready), 32'h1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input int hold, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input bit finish);
    int lat;
    @(negedge clk);
    lat = 1;
    while (!bus.rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h1);
    check({nm, "_rdata"}, bus.rsp_rdata, exp_rd);
    check({nm, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      check({nm, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'h0);
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(bus.rsp_valid), 32'h1);
      check({nm, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
      check({nm, "_hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
    end
    if (finish) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic run_cmd(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int wt,
                         input int hold, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_mv, input int exp_lat);
    int base;
    wait_target = wt;
    @(negedge clk);
    drive(we, addr, wdata, strb);
    base = mv_count;
    accept(nm);
    collect(nm, hold, exp_rd, exp_err, exp_lat, 1'b1);
    check({nm, "_mv_cycles"}, 32'(mv_count - base), 32'(exp_mv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b0;
    exp_maddr  = '0;
    exp_mwdata = '0;
    exp_mwstrb = '0;

    //              we    addr      wdata         strb   wt hold exp_rd        err  mv lat
    tbl[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        1'b0, 1, 2};
    tbl[1]  = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1, 2};
    tbl[2]  = '{1'b1, 32'h20, 32'h11223344, 4'hF, 0, 0, 32'h0,        1'b0, 1, 2};
    tbl[3]  = '{1'b1, 32'h20, 32'h0000AB00, 4'h2, 0, 0, 32'h0,        1'b0, 1, 2};
    tbl[4]  = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 32'h1122AB44, 1'b0, 1, 2};
    tbl[5]  = '{1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 3, 1, 32'h0,        1'b0, 4, 5};
    tbl[6]  = '{1'b0, 32'h24, 32'h0,        4'h0, 3, 2, 32'hCAFEF00D, 1'b0, 4, 5};
    tbl[7]  = '{1'b0, 32'h12, 32'h0,        4'h0, 0, 0, 32'h0,        1'b1, 0, 1};
    tbl[8]  = '{1'b1, 32'h30, 32'h12345678, 4'h0, 0, 0, 32'h0,        1'b1, 0, 1};
    tbl[9]  = '{1'b0, 32'h30, 32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,        1'b0, 1, 2};
    tbl[10] = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'h9, 1, 0, 32'h0,        1'b0, 2, 3};
    tbl[11] = '{1'b0, 32'h3C, 32'h0,        4'h0, 0, 0, 32'hA50000A5, 1'b0, 1, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_instr", 32'(bus.mem_instr), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_cmd($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb,
              tbl[i].wt, tbl[i].hold, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_mv,
              tbl[i].exp_lat);

    // backpressure, then a command offered during the response handshake
    run_cmd("bp_wr", 1'b1, 32'h08, 32'h5A5A0F0F, 4'hF, 0, 5, 32'h0, 1'b0, 1, 2);
    wait_target = 0;
    @(negedge clk);
    drive(1'b0, 32'h08, 32'hFFFF_FFFF, 4'hF);
    accept("ovl_rd");
    collect("ovl_rd", 0, 32'h5A5A0F0F, 1'b0, 2, 1'b0);
    drive(1'b1, 32'h08, 32'h0000_0077, 4'h1);
    bus.rsp_ready = 1'b1;
    check("ovl_cmd_ready_hs", 32'(bus.cmd_ready), 32'h0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("ovl_rsp_valid_after", 32'(bus.rsp_valid), 32'h0);
    check("ovl_no_early_accept", 32'(bus.mem_valid), 32'h0);
    check("ovl_cmd_ready_after", 32'(bus.cmd_ready), 32'h1);
    base = mv_count;
    accept("ovl_wr");
    collect("ovl_wr", 0, 32'h0, 1'b0, 2, 1'b1);
    check("ovl_wr_mv_cycles", 32'(mv_count - base), 32'h1);
    run_cmd("ovl_chk", 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 32'h5A5A0F77, 1'b0, 1, 2);

    // reset in the middle of a stalled request
    ready_en = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h0C, 32'h01020304, 4'hF);
    accept("rst_req");
    @(negedge clk);
    check("rst_req_mem_valid", 32'(bus.mem_valid), 32'h1);
    check("rst_req_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_abort_mem_valid", 32'(bus.mem_valid), 32'h0);
    check("rst_abort_busy", 32'(busy), 32'h0);
    check("rst_abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    check("rst_abort_rsp_valid2", 32'(bus.rsp_valid), 32'h0);
    ready_en = 1'b1;

`ifdef NATIVE_MEM_INITIATOR_TIMEOUT_EN
    run_cmd("to_late_ok", 1'b0, 32'h10, 32'h0, 4'h0, 15, 0, 32'hDEADBEEF, 1'b0, 16, 17);
    ready_en = 1'b0;
    run_cmd("to_expire", 1'b0, 32'h10, 32'h0, 4'h0, 0, 1, 32'h0, 1'b1, 16, 17);
    ready_en = 1'b1;
`endif

    for (int i = 0; i < 16; i++) rmem[i] = '0;
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h00;
    for (int n = 0; n < 150; n++) begin
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] erd;
      logic        eerr;
      int          wt;
      int          word;
      we    = 1'($urandom_range(0, 1));
      word  = int'($urandom_range(0, 15));
      addr  = 32'(word * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      wdata = $urandom;
      strb  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wt    = int'($urandom_range(0, 3));
      stray_en = 1'($urandom_range(0, 1));
      eerr  = (addr % 4 != 0) || (we && strb == 4'h0);
      erd   = 32'h0;
      if (!eerr) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) ref_bytes[word * 4 + b] = wdata[8*b +: 8];
        end else begin
          erd = {ref_bytes[word*4+3], ref_bytes[word*4+2], ref_bytes[word*4+1], ref_bytes[word*4]};
        end
      end
      run_cmd($sformatf("rnd%0d", n), we, addr, wdata, strb, wt, int'($urandom_range(0, 2)),
              erd, eerr, eerr ? 0 : wt + 1, eerr ? 1 : wt + 2);
    end
    stray_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
